// File: rtl/pito_uart_rx_mmio.sv
// 8N1 UART receiver with a small receive FIFO and a one-cycle-latency
// memory-mapped read port (data pop and sticky status flags) for the pito SoC.
module pito_uart_rx_mmio #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter logic [31:0] DATA_ADDR    = 32'h8000_0004,
  parameter logic [31:0] STAT_ADDR    = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic        rd_req,
  input  logic        rd_we,
  input  logic [31:0] rd_addr,
  output logic [31:0] rd_rdata,
  output logic        rd_hit,
  output logic        rx_avail
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic             rx_meta, rx_s;
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shreg, shreg_n;
  logic             armed, armed_n;
  logic             push, frm_set;

  // NOTE: every clocked process uses non-blocking assignments so that all
  // flops update together; a blocking assignment here would collapse the
  // two-stage synchronizer into a single stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    armed_n   = 1'b0;
    push      = 1'b0;
    frm_set   = 1'b0;
    unique case (state)
      IDLE: begin
        armed_n = armed | rx_s;
        if (armed && !rx_s) begin
          state_n = START;
          cnt_n   = '0;
          armed_n = 1'b0;
        end
      end
      START: begin
        if (cnt == HALF_CNT) begin
          if (!rx_s) begin
            state_n   = DATA;
            cnt_n     = '0;
            bit_idx_n = '0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt == BIT_END) begin
          cnt_n     = '0;
          shreg_n   = {rx_s, shreg[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = STOP;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt == BIT_END) begin
          push    = rx_s;
          frm_set = !rx_s;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      armed   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
      armed   <= armed_n;
    end
  end

  // Receive FIFO; the extra pointer bit separates full from empty.
  logic [7:0]     mem [FIFO_DEPTH];
  logic [PTR_W:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic           empty, full, pop, push_ok, ovr_set;
  logic           data_rd, stat_rd;
  logic           frm, ovr;
  logic [7:0]     head;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign head    = mem[rd_ptr[PTR_W-1:0]];
  assign data_rd = rd_req && !rd_we && (rd_addr == DATA_ADDR);
  assign stat_rd = rd_req && !rd_we && (rd_addr == STAT_ADDR);
  assign pop     = data_rd && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok = push && (!full || pop);
  assign ovr_set = push && full && !pop;
  assign wr_ptr_n = push_ok ? wr_ptr + (PTR_W + 1)'(1) : wr_ptr;
  assign rd_ptr_n = pop     ? rd_ptr + (PTR_W + 1)'(1) : rd_ptr;

  // NOTE: the storage array has no reset; only the pointers define which
  // entries are valid, so clearing the data would buy nothing.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[PTR_W-1:0]] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      frm      <= 1'b0;
      ovr      <= 1'b0;
      rd_hit   <= 1'b0;
      rd_rdata <= '0;
      rx_avail <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_n;
      rd_ptr   <= rd_ptr_n;
      frm      <= frm_set | (frm & !stat_rd);
      ovr      <= ovr_set | (ovr & !stat_rd);
      rd_hit   <= data_rd | stat_rd;
      rx_avail <= (wr_ptr_n != rd_ptr_n);
      if (data_rd)      rd_rdata <= {24'b0, empty ? 8'h00 : head};
      else if (stat_rd) rd_rdata <= {28'b0, frm, ovr, full, !empty};
      else              rd_rdata <= '0;
    end
  end

endmodule

// File: tb/tb_pito_uart_rx_mmio.sv
// Bench for pito_uart_rx_mmio: serial frames are driven bit by bit while a
// queue-based model predicts every read response and rx_avail each cycle.
module tb_pito_uart_rx_mmio;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] DATA_ADDR = 32'h8000_0004;
  localparam logic [31:0] STAT_ADDR = 32'h8000_0008;
  // Edges from driving the start bit to the stop-bit decision:
  // 2 sync + 1 detect + half bit + 8 data bits + stop bit.
  localparam int FRAME_LAT = 3 + CPB / 2 + 9 * CPB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx = 1'b1;
  logic        rd_req = 1'b0;
  logic        rd_we = 1'b0;
  logic [31:0] rd_addr = '0;
  logic [31:0] rd_rdata;
  logic        rd_hit;
  logic        rx_avail;

  pito_uart_rx_mmio #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .DATA_ADDR   (DATA_ADDR),
    .STAT_ADDR   (STAT_ADDR)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rx      (rx),
    .rd_req  (rd_req),
    .rd_we   (rd_we),
    .rd_addr (rd_addr),
    .rd_rdata(rd_rdata),
    .rd_hit  (rd_hit),
    .rx_avail(rx_avail)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: byte queue, sticky flags, scheduled frame outcomes.
  int          cyc = 0;
  bit          started = 1'b0;
  logic [7:0]  mq[$];
  logic        m_frm = 1'b0, m_ovr = 1'b0;
  logic [31:0] e_rdata = '0;
  logic        e_hit = 1'b0, e_avail = 1'b0;
  int          ev_cyc[$];
  logic [7:0]  ev_byte[$];
  logic        ev_ok[$];

  always @(posedge clk) begin
    logic d_rd, s_rd, pop, do_push, fset, oset;
    logic [7:0] pb;
    cyc++;
    started = 1'b1;
    if (rst) begin
      mq.delete();
      ev_cyc.delete();
      ev_byte.delete();
      ev_ok.delete();
      m_frm = 1'b0;
      m_ovr = 1'b0;
      e_rdata = '0;
      e_hit = 1'b0;
      e_avail = 1'b0;
    end else begin
      d_rd = rd_req && !rd_we && rd_addr == DATA_ADDR;
      s_rd = rd_req && !rd_we && rd_addr == STAT_ADDR;
      do_push = 1'b0; fset = 1'b0; oset = 1'b0; pop = 1'b0; pb = 8'h00;
      if (ev_cyc.size() > 0 && ev_cyc[0] == cyc) begin
        if (ev_ok[0]) begin do_push = 1'b1; pb = ev_byte[0]; end
        else fset = 1'b1;
        void'(ev_cyc.pop_front());
        void'(ev_byte.pop_front());
        void'(ev_ok.pop_front());
      end
      e_hit = d_rd || s_rd;
      e_rdata = '0;
      if (d_rd) begin
        if (mq.size() > 0) begin e_rdata = {24'b0, mq[0]}; pop = 1'b1; end
      end else if (s_rd) begin
        e_rdata = {28'b0, m_frm, m_ovr, mq.size() == DEPTH, mq.size() != 0};
      end
      if (pop) void'(mq.pop_front());
      if (do_push) begin
        if (mq.size() < DEPTH) mq.push_back(pb);
        else oset = 1'b1;
      end
      m_frm = fset | (m_frm & !s_rd);
      m_ovr = oset | (m_ovr & !s_rd);
      e_avail = mq.size() != 0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("cyc_rd_hit", {31'b0, rd_hit}, {31'b0, e_hit});
      check("cyc_rd_rdata", rd_rdata, e_rdata);
      check("cyc_rx_avail", {31'b0, rx_avail}, {31'b0, e_avail});
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(posedge clk); #1;
    ev_cyc.push_back(cyc + FRAME_LAT);
    ev_byte.push_back(b);
    ev_ok.push_back(stop);
    rx = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(posedge clk);
      #1 rx = b[i];
    end
    repeat (CPB) @(posedge clk);
    #1 rx = stop;
    repeat (CPB + 2) @(posedge clk);
    #1;
  endtask

  // at_cyc == 0: issue on the next cycle; otherwise the DUT sees the
  // request on the edge where the model counter reaches at_cyc.
  task automatic do_read(input logic [31:0] addr, input int at_cyc,
                         output logic [31:0] data, output logic hit);
    if (at_cyc == 0) begin
      @(posedge clk); #1;
    end else begin
      while (cyc < at_cyc - 1) begin @(posedge clk); #1; end
    end
    rd_req = 1'b1; rd_we = 1'b0; rd_addr = addr;
    @(posedge clk); #1;
    rd_req = 1'b0; rd_addr = '0;
    data = rd_rdata;
    hit = rd_hit;
  endtask

  task automatic do_write(input logic [31:0] addr);
    @(posedge clk); #1;
    rd_req = 1'b1; rd_we = 1'b1; rd_addr = addr;
    @(posedge clk); #1;
    rd_req = 1'b0; rd_we = 1'b0; rd_addr = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    logic h;
    logic [7:0] fill_bytes [4];
    int tgt;
    fill_bytes = '{8'h40, 8'h41, 8'h42, 8'h43};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_rd_rdata", rd_rdata, 32'h0);
    check("reset_rd_hit", {31'b0, rd_hit}, 32'h0);
    check("reset_rx_avail", {31'b0, rx_avail}, 32'h0);
    idle(6);

    // Single frame, ignored write, data pop.
    send_frame(8'hA5, 1'b1);
    check("a5_avail_up", {31'b0, rx_avail}, 32'h1);
    do_write(DATA_ADDR);
    check("write_ignored_avail", {31'b0, rx_avail}, 32'h1);
    do_read(DATA_ADDR, 0, d, h);
    check("a5_data", d, 32'h0000_00A5);
    check("a5_hit", {31'b0, h}, 32'h1);
    idle(1);
    check("a5_avail_down", {31'b0, rx_avail}, 32'h0);

    // Overrun: five bytes into a four-entry FIFO.
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    do_read(STAT_ADDR, 0, d, h);
    check("ovr_status1", d, 32'h0000_0007);
    do_read(STAT_ADDR, 0, d, h);
    check("ovr_status2", d, 32'h0000_0003);
    for (int i = 1; i <= 4; i++) begin
      do_read(DATA_ADDR, 0, d, h);
      check("ovr_data", d, 32'(i));
    end

    // Framing error, held-low line, recovery.
    idle(4);
    send_frame(8'h3C, 1'b0);
    check("frm_no_push", {31'b0, rx_avail}, 32'h0);
    do_read(STAT_ADDR, 0, d, h);
    check("frm_status", d, 32'h0000_0008);
    idle(40);
    check("held_low_no_frame", {31'b0, rx_avail}, 32'h0);
    rx = 1'b1;
    idle(8);
    send_frame(8'h11, 1'b1);
    do_read(DATA_ADDR, 0, d, h);
    check("recover_data", d, 32'h0000_0011);

    // One-cycle glitch in IDLE, then a read of an empty FIFO.
    idle(4);
    rx = 1'b0;
    idle(1);
    rx = 1'b1;
    idle(12);
    check("glitch_no_push", {31'b0, rx_avail}, 32'h0);
    do_read(DATA_ADDR, 0, d, h);
    check("empty_data", d, 32'h0);
    check("empty_hit", {31'b0, h}, 32'h1);
    do_read(STAT_ADDR, 0, d, h);
    check("glitch_status", d, 32'h0);

    // Full FIFO, pop on the same edge as the push of 0x99.
    for (int i = 0; i < 4; i++) send_frame(fill_bytes[i], 1'b1);
    tgt = cyc + 1 + FRAME_LAT;
    fork
      send_frame(8'h99, 1'b1);
      do_read(DATA_ADDR, tgt, d, h);
    join
    check("pop_push_data", d, 32'h0000_0040);
    do_read(STAT_ADDR, 0, d, h);
    check("pop_push_status", d, 32'h0000_0003);
    for (int i = 1; i < 4; i++) begin
      do_read(DATA_ADDR, 0, d, h);
      check("pop_push_drain", d, {24'b0, fill_bytes[i]});
    end
    do_read(DATA_ADDR, 0, d, h);
    check("pop_push_fourth", d, 32'h0000_0099);

    // Reset in the middle of data bit 4.
    send_frame(8'h5A, 1'b1);
    @(posedge clk); #1;
    rx = 1'b0;
    for (int i = 0; i < 5; i++) begin
      repeat (CPB) @(posedge clk);
      #1 rx = i[0];
    end
    idle(2);
    rst = 1'b1;
    rx = 1'b1;
    idle(3);
    rst = 1'b0;
    check("midrst_rd_rdata", rd_rdata, 32'h0);
    check("midrst_rd_hit", {31'b0, rd_hit}, 32'h0);
    check("midrst_rx_avail", {31'b0, rx_avail}, 32'h0);
    idle(8);
    send_frame(8'h6B, 1'b1);
    do_read(STAT_ADDR, 0, d, h);
    check("midrst_status", d, 32'h0000_0001);
    do_read(DATA_ADDR, 0, d, h);
    check("midrst_data", d, 32'h0000_006B);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
